// File: rtl/heq_div_sequencer.sv
// heq_div_sequencer: walks NBINS CDF bins, runs each one through an external
// divider and writes the saturated 8-bit grey level into the equalization LUT.
// Optional divider watchdog: define HEQ_DIV_TIMEOUT_EN to enable it.
module heq_div_sequencer #(
    parameter int NBINS   = 256,
    parameter int CDFMIN  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cdf_rd_en,
    output logic [7:0]  cdf_rd_addr,
    input  logic [31:0] cdf_rd_data,
    output logic        div_enable,
    output logic        div_en,
    output logic [31:0] div_cdf,
    input  logic [31:0] div_g,
    input  logic        div_ready,
    output logic        lut_wr_en,
    output logic [7:0]  lut_wr_addr,
    output logic [7:0]  lut_wr_data
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, LOAD, DIV, WR, NEXT, FIN} state_t;

    localparam logic [7:0]  LAST_BIN = 8'(NBINS - 1);
    localparam logic [31:0] CDF_MIN  = 32'(CDFMIN);

    state_t      state, state_nx;
    logic [7:0]  bin;
    logic [31:0] cdf_q;
    logic [31:0] g_q;
    logic [31:0] div_hold;
    logic        bypass;
    logic        to_hit;

    // Bins below the minimum CDF never reach the divider and map to grey 0.
    assign bypass = (cdf_rd_data < CDF_MIN);

`ifdef HEQ_DIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // Last permitted DIV cycle; the FSM bails out to FIN on it if no quotient.
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
    assign err    = err_q;

    // Watchdog: counts DIV cycles, latches err until reset or the next run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && start)
                err_q <= 1'b0;
            if (state == LOAD)
                to_cnt <= '0;
            else if (state == DIV && !div_ready) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_hit)
                    err_q <= 1'b1;
            end
        end
    end
`else
    // No watchdog: DIV waits forever and err is a constant 0 (the compare
    // below is never true; it only keeps TIMEOUT referenced in this build).
    assign to_hit = 1'b0;
    assign err    = (TIMEOUT < 0);
`endif

    // Divider operand is shown straight from cdf_q in LOAD so the divider can
    // register it that cycle, then held until the next LOAD.
    assign div_cdf = (state == LOAD) ? cdf_q : div_hold;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and strobe decode; every strobe is 0 unless its state owns it.
    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        cdf_rd_en   = 1'b0;
        cdf_rd_addr = 8'd0;
        div_enable  = 1'b0;
        div_en      = 1'b0;
        lut_wr_en   = 1'b0;
        lut_wr_addr = 8'd0;
        lut_wr_data = 8'd0;
        case (state)
            IDLE:  if (start) state_nx = RD;
            RD: begin
                busy        = 1'b1;
                cdf_rd_en   = 1'b1;
                cdf_rd_addr = bin;
                state_nx    = RWAIT;
            end
            RWAIT: begin
                busy     = 1'b1;
                state_nx = bypass ? WR : LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                div_enable = 1'b1;
                state_nx   = DIV;
            end
            DIV: begin
                busy   = 1'b1;
                div_en = 1'b1;
                if (div_ready)   state_nx = WR;
                else if (to_hit) state_nx = FIN;
            end
            WR: begin
                busy        = 1'b1;
                lut_wr_en   = 1'b1;
                lut_wr_addr = bin;
                lut_wr_data = (g_q > 32'd255) ? 8'hFF : g_q[7:0];
                state_nx    = NEXT;
            end
            NEXT: begin
                busy     = 1'b1;
                state_nx = (bin == LAST_BIN) ? FIN : RD;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: bin counter, CDF capture, operand hold and quotient capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin      <= 8'd0;
            cdf_q    <= 32'd0;
            g_q      <= 32'd0;
            div_hold <= 32'd0;
        end else begin
            case (state)
                IDLE:  if (start) bin <= 8'd0;
                RWAIT: begin
                    cdf_q <= cdf_rd_data;
                    if (bypass) g_q <= 32'd0;
                end
                LOAD:  div_hold <= cdf_q;
                DIV:   if (div_ready) g_q <= div_g;
                NEXT:  if (bin != LAST_BIN) bin <= bin + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_heq_div_sequencer.sv
// Bench for heq_div_sequencer: behavioural CDF memory and divider models,
// per-bin expected LUT contents from a table plus randomized bins, and
// hand-written sequences for mid-run reset and divider timeout.
module tb_heq_div_sequencer;

    localparam int NB   = 256;
    localparam int CMIN = 2;   // so that cdf=1 is a bypass bin and cdf=2 is the boundary
    localparam int TO   = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        cdf_rd_en;
    logic [7:0]  cdf_rd_addr;
    logic [31:0] cdf_rd_data = 32'd0;
    logic        div_enable, div_en;
    logic [31:0] div_cdf;
    logic [31:0] div_g;
    logic        div_ready;
    logic        lut_wr_en;
    logic [7:0]  lut_wr_addr, lut_wr_data;

    always #5 clk = ~clk;

    heq_div_sequencer #(.NBINS(NB), .CDFMIN(CMIN), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .err(err),
        .cdf_rd_en(cdf_rd_en), .cdf_rd_addr(cdf_rd_addr), .cdf_rd_data(cdf_rd_data),
        .div_enable(div_enable), .div_en(div_en), .div_cdf(div_cdf), .div_g(div_g),
        .div_ready(div_ready), .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
        .lut_wr_data(lut_wr_data)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- environment models ----------------
    logic [31:0] cdf_mem [NB];
    logic [31:0] g_mem   [NB];
    int          lat_mem [NB];
    bit          stuck   [NB];
    bit          noise_en = 1'b0;
    logic        noise = 1'b0;
    logic [31:0] junk = 32'd0;
    logic [7:0]  rd_bin = 8'd0;
    logic [7:0]  op_bin = 8'd0;
    int          dcnt = 0;

    // CDF memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        cdf_rd_data <= cdf_rd_en ? cdf_mem[cdf_rd_addr] : $urandom;
        if (cdf_rd_en) rd_bin <= cdf_rd_addr;
        noise <= noise_en & $urandom_range(0, 1);
        junk  <= $urandom;
    end

    // Divider: quotient appears on the lat-th cycle of div_en.
    always @(posedge clk) begin
        if (div_enable) begin
            dcnt   <= 0;
            op_bin <= rd_bin;
        end else if (div_en) dcnt <= dcnt + 1;
    end
    assign div_ready = div_en ? (!stuck[op_bin] && dcnt == lat_mem[op_bin] - 1) : noise;
    assign div_g     = (div_en && div_ready) ? g_mem[op_bin] : junk;

    // ---------------- monitor ----------------
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         den_cnt[NB];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (lut_wr_en) begin
            wr_addr_q.push_back(lut_wr_addr);
            wr_data_q.push_back(lut_wr_data);
        end
        if (div_en) den_cnt[rd_bin]++;
        if (done) done_cnt++;
        if (div_enable) check("div_cdf_at_load", div_cdf, cdf_mem[rd_bin]);
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        foreach (den_cnt[i]) den_cnt[i] = 0;
        done_cnt = 0;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_data[NB];
    int         exp_div [NB];

    function automatic logic [7:0] ref_lut(input logic [31:0] c, input logic [31:0] g);
        if (c < CMIN) return 8'd0;
        return (g > 32'd255) ? 8'd255 : g[7:0];
    endfunction

    task automatic fill_random(input int from);
        for (int b = from; b < NB; b++) begin
            cdf_mem[b] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            g_mem[b]   = 32'($urandom_range(0, 400));
            lat_mem[b] = $urandom_range(1, 6);
            stuck[b]   = 1'b0;
            exp_data[b] = ref_lut(cdf_mem[b], g_mem[b]);
            exp_div[b]  = (cdf_mem[b] < CMIN) ? 0 : lat_mem[b];
        end
    endtask

    typedef struct {
        logic [31:0] cdf;
        logic [31:0] g;
        int          lat;
        logic [7:0]  exp_data;
        int          exp_div;
    } vec_t;
    vec_t vt[9];

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
    endtask

    // Full run with a start poke mid-run; compare every LUT write.
    task automatic run_full(input bit poke);
        bit got;
        clear_mon();
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            start = (poke && c == 500);
            if (done) begin got = 1'b1; break; end
        end
        start = 1'b0;
        check("run_done_seen", got, 1);
        repeat (20) @(negedge clk);
        check("busy_after_run", busy, 0);
        check("done_pulses", done_cnt, 1);
        check("write_count", wr_addr_q.size(), NB);
        for (int i = 0; i < NB && i < wr_addr_q.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], i);
            check($sformatf("wr_data[%0d]", i), wr_data_q[i], exp_data[i]);
            check($sformatf("div_en_cycles[%0d]", i), den_cnt[i], exp_div[i]);
        end
    endtask

    initial begin
        bit got;
        // cdf, g, lat, expected LUT data, expected div_en cycles
        vt[0] = '{32'd1,          32'd77,          3,  8'd0,   0};  // bypass
        vt[1] = '{32'd307200,     32'd255,         40, 8'd255, 40};
        vt[2] = '{32'd5000,       32'd300,         5,  8'd255, 5};  // saturate
        vt[3] = '{32'd2,          32'd7,           1,  8'd7,   1};  // cdf == CDFMIN
        vt[4] = '{32'd0,          32'd99,          2,  8'd0,   0};  // bypass
        vt[5] = '{32'd100,        32'd256,         2,  8'd255, 2};
        vt[6] = '{32'd100,        32'hFFFF_FFFF,   3,  8'd255, 3};
        vt[7] = '{32'd100,        32'd0,           1,  8'd0,   1};
        vt[8] = '{32'hFFFF_FFFF,  32'd128,         6,  8'd128, 6};
        for (int i = 0; i < 9; i++) begin
            cdf_mem[i] = vt[i].cdf;  g_mem[i] = vt[i].g;  lat_mem[i] = vt[i].lat;
            stuck[i] = 1'b0;  exp_data[i] = vt[i].exp_data;  exp_div[i] = vt[i].exp_div;
        end
        fill_random(9);
        clear_mon();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);      check("rst_done", done, 0);
        check("rst_err", err, 0);        check("rst_rd_en", cdf_rd_en, 0);
        check("rst_div_en", div_en, 0);  check("rst_div_enable", div_enable, 0);
        check("rst_div_cdf", div_cdf, 0); check("rst_wr_en", lut_wr_en, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        // Table + random bins, start poked mid-run
        run_full(1'b1);

        // Fully random bins with div_ready noise outside DIV
        noise_en = 1'b1;
        fill_random(0);
        run_full(1'b1);
        noise_en = 1'b0;

        // Reset while bin 17 is in DIV
        cdf_mem[17] = 32'd1000;  lat_mem[17] = 50;  g_mem[17] = 32'd9;
        clear_mon();
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (div_en && rd_bin == 8'd17) begin got = 1'b1; break; end
        end
        check("reached_div_bin17", got, 1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);          check("ar_div_en", div_en, 0);
        check("ar_div_cdf", div_cdf, 0);    check("ar_wr_en", lut_wr_en, 0);
        check("ar_rd_en", cdf_rd_en, 0);    check("ar_done", done, 0);
        check("ar_wr_addr", lut_wr_addr, 0); check("ar_rd_addr", cdf_rd_addr, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("ar_write_count", wr_addr_q.size(), 17);
        check("ar_last_addr", (wr_addr_q.size() > 0) ? wr_addr_q[$] : 8'hFF, 16);
        check("ar_stays_idle", busy, 0);
        lat_mem[17] = 2;

        // Divider never answers on bin 3
        cdf_mem[3] = 32'd500;  stuck[3] = 1'b1;
        clear_mon();
        pulse_start();
`ifdef HEQ_DIV_TIMEOUT_EN
        wait_done(3000, got);
        check("to_done_seen", got, 1);
        check("to_err_at_done", err, 1);
        check("to_write_count", wr_addr_q.size(), 3);
        check("to_div_cycles", den_cnt[3], TO);
        repeat (5) @(negedge clk);
        check("to_busy_low", busy, 0);
        check("to_err_sticky", err, 1);
        stuck[3] = 1'b0;
        clear_mon();
        pulse_start();
        check("to_err_clr_on_start", err, 0);
        wait_done(30000, got);
        check("to_rerun_done", got, 1);
        check("to_rerun_writes", wr_addr_q.size(), NB);
`else
        repeat (400) @(negedge clk);
        check("nto_div_en_held", div_en, 1);
        check("nto_busy", busy, 1);
        check("nto_err", err, 0);
        check("nto_write_count", wr_addr_q.size(), 3);
        check("nto_no_done", done_cnt, 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stuck[3] = 1'b0;
        wait_done(20, got);
        check("nto_idle_after_rst", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
